// File: rtl/bird_collision_scorer.sv
// Game-state block: collision/pass detection per movement tick, game FSM,
// 3-digit BCD score with high score and the pipe-generator restart pulse.
module bird_collision_scorer #(
  parameter int unsigned BIRD_X   = 200,
  parameter int unsigned BIRD_W   = 34,
  parameter int unsigned BIRD_H   = 24,
  parameter int unsigned PIPE_W   = 80,
  parameter int unsigned GAP_H    = 160,
  parameter int unsigned FLOOR_Y  = 740,
  parameter int unsigned HIT_HOLD = 30
) (
  input  logic        clk,
  input  logic        RESET_N,
  input  logic        move,
  input  logic        start,
  input  logic [10:0] pipe_x,
  input  logic [10:0] pipe_y,
  input  logic [10:0] bird_y,
  output logic        reset_game,
  output logic        playing,
  output logic        game_over,
  output logic [11:0] score,
  output logic [11:0] high_score
);

  localparam int unsigned CW     = 12;
  localparam int unsigned HOLD_W = $clog2(HIT_HOLD + 1);

  localparam logic [CW-1:0] BIRD_L  = CW'(BIRD_X);
  localparam logic [CW-1:0] BIRD_R  = CW'(BIRD_X + BIRD_W);
  localparam logic [CW-1:0] BIRD_HV = CW'(BIRD_H);
  localparam logic [CW-1:0] PIPE_WV = CW'(PIPE_W);
  localparam logic [CW-1:0] GAP_HV  = CW'(GAP_H);
  localparam logic [CW-1:0] FLOOR_V = CW'(FLOOR_Y);

  typedef enum logic [1:0] {IDLE, PLAY, HIT, OVER} state_e;

  state_e              state_q, state_d;
  logic                sync1_q, sync2_q, sync3_q, tick_q;
  logic [CW-1:0]       score_q, score_d, high_q, high_d;
  logic                armed_q, armed_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                seen_low_q, seen_low_d;
  logic                reset_game_q, reset_game_d;
  logic                playing_q, playing_d;
  logic                game_over_q, game_over_d;
  logic                restart_c;

  // move synchronizer and rising-edge detect; tick is registered for a 3-edge path
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= move;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      tick_q  <= sync2_q & ~sync3_q;
    end
  end

  logic [CW-1:0]        px, py, by, gap_top;
  logic signed [CW-1:0] gap_top_s;
  logic                 x_ovl, in_gap, hit_c, pass_c, wrap_c;

  assign px        = CW'(pipe_x);
  assign py        = CW'(pipe_y);
  assign by        = CW'(bird_y);
  assign gap_top_s = $signed(py) - $signed(GAP_HV);
  assign gap_top   = gap_top_s[CW-1] ? '0 : $unsigned(gap_top_s);
  assign x_ovl     = (px < BIRD_R) && (BIRD_L < px + PIPE_WV);
  assign in_gap    = (by >= gap_top) && (by + BIRD_HV <= py);
  assign hit_c     = (x_ovl && !in_gap) || (by + BIRD_HV > FLOOR_V);
  assign pass_c    = (px + PIPE_WV < BIRD_L);
  assign wrap_c    = (px >= BIRD_R);

  function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
    logic [3:0] d0, d1, d2;
    {d2, d1, d0} = v;
    if (v == 12'h999) return v;
    if (d0 != 4'd9) begin
      d0 = d0 + 4'd1;
    end else begin
      d0 = 4'd0;
      if (d1 != 4'd9) begin
        d1 = d1 + 4'd1;
      end else begin
        d1 = 4'd0;
        d2 = d2 + 4'd1;
      end
    end
    return {d2, d1, d0};
  endfunction

  // next-state and output logic
  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    high_d       = high_q;
    armed_d      = armed_q;
    hold_d       = hold_q;
    seen_low_d   = seen_low_q;
    reset_game_d = 1'b0;
    restart_c    = 1'b0;

    if (tick_q && wrap_c) armed_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start) restart_c = 1'b1;
      end
      PLAY: begin
        if (tick_q) begin
          if (hit_c) begin
            state_d = HIT;
            hold_d  = HOLD_W'(HIT_HOLD);
          end else if (pass_c && armed_q) begin
            score_d = bcd_inc(score_q);
            armed_d = 1'b0;
          end
        end
      end
      HIT: begin
        if (tick_q) begin
          if (hold_q <= HOLD_W'(1)) begin
            state_d    = OVER;
            hold_d     = '0;
            seen_low_d = 1'b0;
            // plain binary compare orders packed BCD digits correctly
            if (score_q > high_q) high_d = score_q;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
      end
      OVER: begin
        if (!start)          seen_low_d = 1'b1;
        else if (seen_low_q) restart_c  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (restart_c) begin
      reset_game_d = 1'b1;
      score_d      = '0;
      armed_d      = 1'b1;
      seen_low_d   = 1'b0;
      state_d      = PLAY;
    end

    playing_d   = (state_d == PLAY);
    game_over_d = (state_d == HIT) || (state_d == OVER);
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      score_q      <= '0;
      high_q       <= '0;
      armed_q      <= 1'b1;
      hold_q       <= '0;
      seen_low_q   <= 1'b0;
      reset_game_q <= 1'b0;
      playing_q    <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      high_q       <= high_d;
      armed_q      <= armed_d;
      hold_q       <= hold_d;
      seen_low_q   <= seen_low_d;
      reset_game_q <= reset_game_d;
      playing_q    <= playing_d;
      game_over_q  <= game_over_d;
    end
  end

  assign reset_game = reset_game_q;
  assign playing    = playing_q;
  assign game_over  = game_over_q;
  assign score      = score_q;
  assign high_score = high_q;

endmodule

// File: tb/tb_bird_collision_scorer.sv
// Directed plus randomized bench for bird_collision_scorer against a
// game-rule reference model kept in plain integers.
module tb_bird_collision_scorer;

  logic        clk = 1'b0;
  logic        RESET_N, move, start;
  logic [10:0] pipe_x, pipe_y, bird_y;
  logic        reset_game, playing, game_over;
  logic [11:0] score, high_score;

  int errors = 0;
  int checks = 0;

  localparam int M_IDLE = 0, M_PLAY = 1, M_HIT = 2, M_OVER = 3;
  int m_mode, m_score, m_high, m_hold;
  bit m_armed, m_released;

  bird_collision_scorer dut (
    .clk(clk), .RESET_N(RESET_N), .move(move), .start(start),
    .pipe_x(pipe_x), .pipe_y(pipe_y), .bird_y(bird_y),
    .reset_game(reset_game), .playing(playing), .game_over(game_over),
    .score(score), .high_score(high_score)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int v);
    return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".playing"},    12'(playing),   12'(m_mode == M_PLAY));
    chk({tag, ".game_over"},  12'(game_over), 12'(m_mode == M_HIT || m_mode == M_OVER));
    chk({tag, ".score"},      score,          to_bcd(m_score));
    chk({tag, ".high_score"}, high_score,     to_bcd(m_high));
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_score = 0; m_high = 0; m_hold = 0;
    m_armed = 1'b1; m_released = 1'b0;
  endtask

  // one movement step with the given geometry, then apply the game rules
  task automatic do_tick(input int px, input int py, input int by);
    int  gap_top;
    bit  x_ovl, in_gap, hit, pass;
    pipe_x = 11'(px); pipe_y = 11'(py); bird_y = 11'(by);
    move = 1'b1;
    repeat (5) @(posedge clk);
    move = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    gap_top = (py - 160 < 0) ? 0 : py - 160;
    x_ovl   = (px < 200 + 34) && (200 < px + 80);
    in_gap  = (by >= gap_top) && (by + 24 <= py);
    hit     = (x_ovl && !in_gap) || (by + 24 > 740);
    pass    = (px + 80 < 200);
    if (px >= 234) m_armed = 1'b1;
    case (m_mode)
      M_PLAY: begin
        if (hit) begin
          m_mode = M_HIT; m_hold = 30;
        end else if (pass && m_armed) begin
          if (m_score < 999) m_score++;
          m_armed = 1'b0;
        end
      end
      M_HIT: begin
        m_hold--;
        if (m_hold == 0) begin
          m_mode = M_OVER;
          m_released = (start == 1'b0);
          if (m_score > m_high) m_high = m_score;
        end
      end
      default: ;
    endcase
    chk_all("tick");
  endtask

  task automatic set_start(input logic v);
    start = v;
    repeat (2) @(posedge clk);
    #1;
    if (m_mode == M_OVER && !v) m_released = 1'b1;
  endtask

  // one-cycle press; a restart is expected only from IDLE or after a release in OVER
  task automatic press_start(input string tag);
    bit exp_rs;
    exp_rs = (m_mode == M_IDLE) || (m_mode == M_OVER && m_released);
    start = 1'b1;
    @(posedge clk); #1;
    if (exp_rs) begin
      m_mode = M_PLAY; m_score = 0; m_armed = 1'b1; m_released = 1'b0;
    end
    chk({tag, ".reset_game"}, 12'(reset_game), 12'(exp_rs));
    chk_all(tag);
    start = 1'b0;
    @(posedge clk); #1;
    if (m_mode == M_OVER) m_released = 1'b1;
    chk({tag, ".pulse_end"}, 12'(reset_game), 12'h000);
  endtask

  initial begin
    RESET_N = 1'b0; move = 1'b0; start = 1'b0;
    pipe_x = '0; pipe_y = '0; bird_y = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) RESET_N = 1'b1;
    @(posedge clk); #1;
    chk("reset.reset_game", 12'(reset_game), 12'h000);
    chk_all("reset");

    // move toggling in IDLE changes nothing
    repeat (3) do_tick(500, 420, 300);
    chk("idle.reset_game", 12'(reset_game), 12'h000);

    press_start("start1");

    // two full pipe sweeps through the gap
    for (int x = 723; x >= 0; x -= 3) do_tick(x, 420, 300);
    chk("one_pass", score, 12'h001);
    do_tick(1023, 420, 300);
    for (int x = 723; x >= 0; x -= 3) do_tick(x, 420, 300);
    chk("two_passes", score, 12'h002);

    // pipe collision, then the hold period
    do_tick(220, 420, 100);
    chk("pipe_hit.game_over", 12'(game_over), 12'h001);
    repeat (29) do_tick(1023, 420, 300);
    chk("hold29.playing", 12'(playing), 12'h000);
    do_tick(1023, 420, 300);
    chk("over.high_score", high_score, 12'h002);

    // floor collision with start held across HIT->OVER
    press_start("restart1");
    do_tick(1023, 420, 720);
    chk("floor_hit.game_over", 12'(game_over), 12'h001);
    set_start(1'b1);
    repeat (30) do_tick(1023, 420, 300);
    press_start("held");
    press_start("restart2");
    chk("restart2.score", score, 12'h000);

    // randomized play
    for (int i = 0; i < 200; i++) begin
      if (m_mode == M_OVER) begin
        press_start("rnd_restart");
      end else begin
        int px;
        case ($urandom_range(0, 3))
          0: px = 1023;
          1: px = $urandom_range(0, 119);
          default: px = $urandom_range(0, 1023);
        endcase
        do_tick(px, $urandom_range(0, 900), $urandom_range(0, 760));
      end
    end

    // get back into PLAY and saturate the score
    for (int i = 0; i < 40 && m_mode != M_PLAY; i++) begin
      if (m_mode == M_HIT) do_tick(1023, 420, 300);
      else press_start("sat_restart");
    end
    for (int i = 0; i < 1000; i++) begin
      do_tick(1023, 420, 300);
      do_tick(0, 420, 300);
    end
    chk("saturate", score, 12'h999);

    // asynchronous reset in the middle of HIT
    do_tick(1023, 420, 720);
    repeat (5) do_tick(1023, 420, 300);
    chk("mid_hit.game_over", 12'(game_over), 12'h001);
    @(posedge clk); #3;
    RESET_N = 1'b0;
    #1;
    model_reset();
    chk("async_rst.reset_game", 12'(reset_game), 12'h000);
    chk_all("async_rst");
    @(negedge clk) RESET_N = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk_all("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bird_collision_scorer.md
# bird_collision_scorer

Game-state block directly downstream of the pipe generator. It consumes the pipe position (`pipe_x`, `pipe_y`) and the bird's vertical position, checks for collisions and pipe passes once per movement step, and runs the game state machine. It keeps a 3-digit BCD score and a high score, and issues the one-cycle `reset_game` pulse that restarts the pipe generator.

## Interface
Parameters:
- `BIRD_X`, 200: bird left column (px)
- `BIRD_W`, 34: bird width
- `BIRD_H`, 24: bird height
- `PIPE_W`, 80: pipe width
- `GAP_H`, 160: gap height; gap rows are `pipe_y-GAP_H` to `pipe_y-1`
- `FLOOR_Y`, 740: first floor row
- `HIT_HOLD`, 30: move ticks spent in HIT

Ports:
- `clk` in 1: system clock
- `RESET_N` in 1: asynchronous, active-low reset
- `move` in 1: movement step, asynchronous level; each rising edge is one tick
- `start` in 1: start/flap button, synchronous, level
- `pipe_x` in 11: pipe left edge
- `pipe_y` in 11: top row of lower pipe
- `bird_y` in 11: bird top row
- `reset_game` out 1: one-cycle pulse to the pipe generator
- `playing` out 1: high in PLAY
- `game_over` out 1: high in HIT and OVER
- `score` out 12: 3 BCD digits, `[11:8]` hundreds
- `high_score` out 12: BCD, best score since reset

## Operation
- `move` passes through a 2-flop synchronizer and a rising-edge detect, producing internal `tick` (one `clk` cycle wide).
- All comparisons are 12-bit unsigned, so `pipe_x+PIPE_W` never wraps.
- `x_ovl`: `pipe_x < BIRD_X+BIRD_W` and `BIRD_X < pipe_x+PIPE_W`.
- `in_gap`: `bird_y >= pipe_y-GAP_H` and `bird_y+BIRD_H <= pipe_y`. Use 12-bit signed for `pipe_y-GAP_H`; a negative value clamps to 0.
- `hit`: `(x_ovl and not in_gap)` or `bird_y+BIRD_H > FLOOR_Y`.
- `pass`: `pipe_x+PIPE_W < BIRD_X`.
- `armed` flag:
  - Cleared when a point is scored.
  - Set on a tick with `pipe_x >= BIRD_X+BIRD_W` (the pipe has wrapped to the right of the bird).
  - Set on entry to PLAY.
- FSM states: IDLE, PLAY, HIT, OVER.
- IDLE:
  - On `start`=1: pulse `reset_game`, clear `score`, set `armed`, go to PLAY.
- PLAY, evaluated on `tick` only:
  - If `hit`: go to HIT and load the hold counter with `HIT_HOLD`.
  - Else if `pass` and `armed`: BCD increment `score`, clear `armed`. 999 saturates (stays 999).
  - `hit` has priority over `pass` on the same tick; no point is scored on that tick.
- HIT:
  - Hold counter decrements on each tick. Leave HIT on the tick where the counter reads 1 (counter reaches 0), and go to OVER.
  - On that same exit cycle, if `score > high_score`, copy `score` to `high_score` (BCD compare, hundreds digit first).
  - `start` is ignored in HIT.
- OVER:
  - Wait for `start` to fall to 0 and then rise again (edge), so a held button cannot restart the game.
  - Then behave as IDLE's start: pulse `reset_game`, clear `score`, set `armed`, go to PLAY.
- `start` in PLAY has no effect; flap physics is a separate block.

## Timing
- Reset values: FSM=IDLE, `reset_game`=0, `playing`=0, `game_over`=0, `score`=0, `high_score`=0, `armed`=1, hold counter=0, synchronizer flops=0.
- `RESET_N` low forces these values immediately, in any state, including mid-HIT.
- The `move` → `tick` path is 3 `clk` edges. `move` first sampled high on edge k gives `tick` high in the cycle after edge k+2, and state/score registers update on edge k+3.
- `pipe_x`, `pipe_y` and `bird_y` must be stable for at least 3 cycles after a `move` rise. They are sampled on the tick edge.
- `reset_game` goes high in the cycle after `start` is sampled, for exactly 1 cycle. `playing` rises on the same edge.
- `game_over` rises on the edge that enters HIT.
- `high_score` changes only on the HIT→OVER edge.
- A `move` rise while in IDLE or OVER is detected but has no effect.

## Test plan
- Reset release with `move` toggling: all outputs stay at 0. Then `start`=1 for 1 cycle → `reset_game` high for exactly 1 cycle, `playing`=1.
- `bird_y`=300, `pipe_y`=420 (gap 260–419). Step `pipe_x` 723→0 in steps of 3, then 1023, then back below `BIRD_X` → `score`=001 after the first pass, 002 after the second; never a double count.
- `bird_y`=100, `pipe_y`=420, `pipe_x`=220 on a tick → `game_over`=1. After 30 further ticks → OVER, `high_score` = `score`.
- `bird_y`=720 (bottom edge 744 > 740), pipe far away → hit on the next tick.
- Hold `start`=1 through the whole HIT→OVER transition → no restart. Release, then press `start` → `reset_game` pulses and `score` resets to 000.
- Preload `score`=999 and pass a pipe → `score` stays 999. Assert `RESET_N`=0 mid-HIT → immediately IDLE with all outputs 0.
